cm0_dap_cdc_capt_bank: RTL
==========================

CM0_DAP_CDC_CAPT_BANK -- requirements
Module: cm0_dap_cdc_capt_bank

Interface
REQ-001 Parameter PRESENT, default 1: 0 removes the block; outputs tie to constants (REGDO=RESET_VAL, VALID=0, ACKTOG=0, OVERRUN=0).
REQ-002 Parameter WIDTH, default 8: capture data width, legal 1..32.
REQ-003 Parameter SYNC_STAGES, default 2: REQTOG synchroniser depth, legal 2..4.
REQ-004 Parameter RESET_VAL, default all ones (WIDTH bits): REGDO reset value.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 REGCLK  in  1  register clock; sole clock, all state on rising edge.
REQ-007 REGRESET  in  1  synchronous active-high reset.
REQ-008 REQTOG  in  1  asynchronous request toggle from source domain; each transition announces new REGDI.
REQ-009 REGDI  in  WIDTH  asynchronous data; stable from REQTOG transition until matching ACKTOG transition.
REQ-010 ACKTOG  out  1  acknowledge toggle returned to source domain.
REQ-011 REGDO  out  WIDTH  captured data, registered.
REQ-012 VALID  out  1  REGDO holds unconsumed data.
REQ-013 READY  in  1  consumer accepts REGDO when VALID&READY.
REQ-014 OVERRUN  out  1  sticky protocol-violation flag (macro-gated).
REQ-015 OVRCLR  in  1  synchronous clear of OVERRUN.

Function
REQ-016 REQTOG passes through SYNC_STAGES flops; internal req_seen holds last accepted toggle level; edge = sync_out XOR req_seen.
REQ-017 FSM states IDLE and HOLD only; REGDI sampled only in IDLE on edge.
REQ-018 IDLE with edge: REGDO<=REGDI, req_seen<=sync_out, VALID<=1, go HOLD.
REQ-019 Latency: REQTOG transition first sampled at edge N gives REGDO/VALID updated at edge N+SYNC_STAGES.
REQ-020 HOLD: REGDO and VALID held regardless of REGDI/REQTOG activity.
REQ-021 HOLD with READY=1: VALID<=0, ACKTOG<=~ACKTOG, go IDLE, in the same edge.
REQ-022 HOLD with edge: source protocol violation; OVERRUN<=1, data not captured, req_seen unchanged; edge stays pending and captures on first IDLE cycle.
REQ-023 HOLD with READY and edge same cycle: handshake completes per REQ-021 and OVERRUN sets; pending edge captures next cycle.
REQ-024 OVRCLR and OVERRUN set in same cycle: set wins.
REQ-025 VALID never asserts except on an IDLE capture; ACKTOG toggles exactly once per consumed capture.

Reset
REQ-026 REGRESET=1 at an edge: sync chain=0, req_seen=0, ACKTOG=0, VALID=0, OVERRUN=0, REGDO=RESET_VAL, state IDLE; overrides all other inputs.
REQ-027 Reset mid-operation: in-flight data dropped; if REQTOG=1 after reset, it is detected as a new edge and captured SYNC_STAGES edges after release.

Configuration
REQ-028 Macro CM0_DAP_CDC_CAPT_OVERRUN_EN defined: OVERRUN logic and OVRCLR active per REQ-022..024.
REQ-029 Macro undefined: OVERRUN ties 0, OVRCLR ignored, no flop inferred; pending-edge behaviour of REQ-022/023 unchanged.

Structure
REQ-030 Package cm0_dap_cdc_pkg holds FSM state enum and constants for WIDTH and SYNC_STAGES legal limits.
REQ-031 Sub-module cm0_dap_cdc_sync (SYNC_STAGES-deep flop chain, reset 0) implements the synchroniser; single instance.

Verification
REQ-032 Reset, WIDTH=8 -> REGDO=8'hFF, VALID=0, ACKTOG=0, OVERRUN=0.
REQ-033 SYNC_STAGES=2, REGDI=8'hA5, REQTOG 0->1 before edge N -> VALID=1, REGDO=8'hA5 at edge N+2; READY=1 -> VALID=0, ACKTOG=1 next edge.
REQ-034 REGDI toggling every cycle while in HOLD, READY=0 for 10 cycles -> REGDO stable, VALID=1, ACKTOG unchanged.
REQ-035 Second REQTOG toggle in HOLD (macro on) -> OVERRUN=1 and persists; after READY, second data captured 1 edge later; OVRCLR=1 -> OVERRUN=0.
REQ-036 REQTOG=1 held, REGRESET pulsed during HOLD -> REGDO=RESET_VAL, then recapture SYNC_STAGES edges after release.
REQ-037 PRESENT=0 -> outputs constant across all stimuli above.

Source files
------------

// File: rtl/cm0_dap_cdc_pkg.sv
// Shared types and legal parameter limits for the DAP CDC capture bank.
package cm0_dap_cdc_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } cdc_state_t;

   localparam int WIDTH_MIN       = 1;
   localparam int WIDTH_MAX       = 32;
   localparam int SYNC_STAGES_MIN = 2;
   localparam int SYNC_STAGES_MAX = 4;

   function automatic bit cfg_legal(input int width, input int stages);
      return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
             (stages >= SYNC_STAGES_MIN) && (stages <= SYNC_STAGES_MAX);
   endfunction

endpackage

// File: rtl/cm0_dap_cdc_capt_bank_if.sv
// Toggle-handshake and consumer-side signals of the capture bank.
interface cm0_dap_cdc_capt_bank_if #(
   parameter int WIDTH = 8
);
   logic             reqtog;
   logic [WIDTH-1:0] regdi;
   logic             acktog;
   logic [WIDTH-1:0] regdo;
   logic             valid;
   logic             ready;
   logic             overrun;
   logic             ovrclr;

   modport master (
      output reqtog, regdi, ready, ovrclr,
      input  acktog, regdo, valid, overrun
   );

   modport slave (
      input  reqtog, regdi, ready, ovrclr,
      output acktog, regdo, valid, overrun
   );
endinterface

// File: rtl/cm0_dap_cdc_sync.sv
// Multi-flop synchroniser for a single-bit asynchronous level; clears to 0 on reset.
module cm0_dap_cdc_sync
   import cm0_dap_cdc_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic regclk,
   input  logic regreset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // NOTE: sequential state is written with non-blocking assignments so every
   // flop samples the pre-edge value of its neighbour.
   always_ff @(posedge regclk) begin
      if (regreset) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/cm0_dap_cdc_capt_bank.sv
// Toggle-handshake CDC capture register with valid/ready consumer side.
// Optional sticky overrun detection is enabled by CM0_DAP_CDC_CAPT_OVERRUN_EN.
module cm0_dap_cdc_capt_bank
   import cm0_dap_cdc_pkg::*;
#(
   parameter int               PRESENT     = 1,
   parameter int               WIDTH       = 8,
   parameter int               SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b1}}
) (
   input logic                      regclk,
   input logic                      regreset,
   cm0_dap_cdc_capt_bank_if.slave   bus
);

   if (!cfg_legal(WIDTH, SYNC_STAGES)) begin : g_cfg_check
      $error("cm0_dap_cdc_capt_bank: WIDTH or SYNC_STAGES out of range");
   end

   if (PRESENT != 0) begin : g_present

      cdc_state_t       state_q, state_d;
      logic [WIDTH-1:0] regdo_q, regdo_d;
      logic             valid_q, valid_d;
      logic             acktog_q, acktog_d;
      logic             req_seen_q, req_seen_d;
      logic             sync_out;
      logic             req_edge;
      logic             ovr_set;

      cm0_dap_cdc_sync #(
         .STAGES (SYNC_STAGES)
      ) u_sync (
         .regclk   (regclk),
         .regreset (regreset),
         .d        (bus.reqtog),
         .q        (sync_out)
      );

      // An unaccepted toggle stays visible here until IDLE consumes it.
      assign req_edge = sync_out ^ req_seen_q;

      always_ff @(posedge regclk) begin
         if (regreset) begin
            state_q    <= ST_IDLE;
            regdo_q    <= RESET_VAL;
            valid_q    <= 1'b0;
            acktog_q   <= 1'b0;
            req_seen_q <= 1'b0;
         end else begin
            state_q    <= state_d;
            regdo_q    <= regdo_d;
            valid_q    <= valid_d;
            acktog_q   <= acktog_d;
            req_seen_q <= req_seen_d;
         end
      end

      // NOTE: every output of this block is given a default first, so no
      // path leaves a signal unassigned and no latch is inferred.
      always_comb begin
         state_d    = state_q;
         regdo_d    = regdo_q;
         valid_d    = valid_q;
         acktog_d   = acktog_q;
         req_seen_d = req_seen_q;
         ovr_set    = 1'b0;

         unique case (state_q)
            ST_IDLE: begin
               if (req_edge) begin
                  regdo_d    = bus.regdi;
                  req_seen_d = sync_out;
                  valid_d    = 1'b1;
                  state_d    = ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (bus.ready) begin
                  valid_d  = 1'b0;
                  acktog_d = ~acktog_q;
                  state_d  = ST_IDLE;
               end
               ovr_set = req_edge;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      assign bus.regdo  = regdo_q;
      assign bus.valid  = valid_q;
      assign bus.acktog = acktog_q;

`ifdef CM0_DAP_CDC_CAPT_OVERRUN_EN
      logic overrun_q;

      always_ff @(posedge regclk) begin
         if (regreset) begin
            overrun_q <= 1'b0;
         end else if (ovr_set) begin
            overrun_q <= 1'b1;
         end else if (bus.ovrclr) begin
            overrun_q <= 1'b0;
         end
      end

      assign bus.overrun = overrun_q;
`else
      logic unused_ovr;
      assign unused_ovr  = &{1'b0, ovr_set, bus.ovrclr};
      assign bus.overrun = 1'b0;
`endif

   end else begin : g_absent

      logic unused_in;
      assign unused_in = &{1'b0, regclk, regreset, bus.reqtog, bus.regdi,
                           bus.ready, bus.ovrclr};

      assign bus.regdo   = RESET_VAL;
      assign bus.valid   = 1'b0;
      assign bus.acktog  = 1'b0;
      assign bus.overrun = 1'b0;

   end

endmodule
